// File: rtl/sm_debug_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sm_debug_ctrl_pkg
// Shared constants for the schoolMIPS run-control sequencer:
//   DBG_OP_*     command opcodes carried on cmdOp
//   DBG_CAUSE_*  codes reported on haltCause
//   dbg_state_e  sequencer state encoding (DBG_ST_HALT / RUN / STEP)
// Imported by sm_debug_ctrl and sm_debug_bp.
// ---------------------------------------------------------------------------
package sm_debug_ctrl_pkg;

   localparam logic [2:0] DBG_OP_NOP    = 3'b000;
   localparam logic [2:0] DBG_OP_HALT   = 3'b001;
   localparam logic [2:0] DBG_OP_RUN    = 3'b010;
   localparam logic [2:0] DBG_OP_STEP   = 3'b011;
   localparam logic [2:0] DBG_OP_SET_BP = 3'b100;
   localparam logic [2:0] DBG_OP_CLR_BP = 3'b101;

   localparam logic [1:0] DBG_CAUSE_RESET = 2'b00;
   localparam logic [1:0] DBG_CAUSE_HALT  = 2'b01;
   localparam logic [1:0] DBG_CAUSE_STEP  = 2'b10;
   localparam logic [1:0] DBG_CAUSE_BP    = 2'b11;

   typedef enum logic [1:0] {
      DBG_ST_HALT = 2'b00,
      DBG_ST_RUN  = 2'b01,
      DBG_ST_STEP = 2'b10
   } dbg_state_e;

   // Commands that take the core out of HALT; leaving HALT with one of
   // these arms the breakpoint skip so the resumed instruction executes.
   function automatic logic op_resumes(input logic [2:0] op);
      return (op == DBG_OP_RUN) || (op == DBG_OP_STEP);
   endfunction

endpackage

// File: rtl/sm_debug_bp.sv
// ---------------------------------------------------------------------------
// sm_debug_bp
// Single instruction-address breakpoint: address/valid registers, a full
// 32-bit comparator against the CPU's pc, and the skip flag that lets a
// resumed core execute the instruction it stopped on.
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   set_bp      load addr into the breakpoint and mark it valid
//   clr_bp      invalidate the breakpoint
//   addr        breakpoint word address (used with set_bp)
//   pc          current instruction word address
//   active      sequencer is in RUN or STEP
//   resume      sequencer is leaving HALT this cycle
//   cpu_en      the core retires an instruction this cycle
//   bp_hit      breakpoint matches the current instruction (combinational)
// ---------------------------------------------------------------------------
module sm_debug_bp
   import sm_debug_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        set_bp,
   input  logic        clr_bp,
   input  logic [31:0] addr,
   input  logic [31:0] pc,
   input  logic        active,
   input  logic        resume,
   input  logic        cpu_en,
   output logic        bp_hit
);

   logic [31:0] bp_addr;
   logic        bp_valid;
   logic        skip_bp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bp_addr  <= '0;
         bp_valid <= 1'b0;
      end else if (set_bp) begin
         bp_addr  <= addr;
         bp_valid <= 1'b1;
      end else if (clr_bp) begin
         bp_valid <= 1'b0;
      end
   end

   // Skip covers exactly the first retired instruction after a resume, so
   // restarting on the breakpoint address steps over it once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_bp <= 1'b0;
      end else if (resume) begin
         skip_bp <= 1'b1;
      end else if (cpu_en) begin
         skip_bp <= 1'b0;
      end
   end

   assign bp_hit = bp_valid && (pc == bp_addr) && !skip_bp && active;

endmodule

// File: rtl/sm_debug_ctrl.sv
// ---------------------------------------------------------------------------
// sm_debug_ctrl
// Run-control sequencer for the schoolMIPS single-cycle core. Produces
// cpuEn, which gates the PC update and register-file write in sm_cpu, and
// executes HALT / RUN / STEP / SET_BP / CLR_BP debug commands.
//
// Build option: SM_DEBUG_BREAKPOINT_EN
//   defined   -> sm_debug_bp is built; SET_BP/CLR_BP program a breakpoint.
//   undefined -> no breakpoint hardware; SET_BP/CLR_BP behave as NOP.
//
// Parameters:
//   STEP_W     width of the step counter (STEP count = cmdArg[STEP_W-1:0])
//   RESET_RUN  1: leave reset in RUN, 0: leave reset in HALT
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   cmdValid    command present            (in)
//   cmdReady    command can be accepted    (out)
//   cmdOp       command opcode, 3 bits     (in)
//   cmdArg      step count / bp address    (in)
//   haltReq     level halt request, highest priority (in)
//   pc          CPU instruction word address (in)
//   cpuEn       core retires the instruction at pc this cycle (out)
//   halted      sequencer is in HALT       (out)
//   haltCause   reason for the last entry into HALT (out)
//   stepCnt     instructions left in the current STEP (out)
//   dbgState    current sequencer state    (out, observation only)
//
// Command handshake: a command transfers on the rising clock edge where
// cmdValid and cmdReady are both 1. cmdReady is low during STEP and in any
// cycle where haltReq or a breakpoint hit forces HALT; a producer holds
// cmdValid/cmdOp/cmdArg stable until the transfer edge.
// ---------------------------------------------------------------------------
module sm_debug_ctrl
   import sm_debug_ctrl_pkg::*;
#(
   parameter int unsigned STEP_W    = 16,
   parameter bit          RESET_RUN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic [2:0]        cmdOp,
   input  logic [31:0]       cmdArg,
   input  logic              haltReq,
   input  logic [31:0]       pc,
   output logic              cpuEn,
   output logic              halted,
   output logic [1:0]        haltCause,
   output logic [STEP_W-1:0] stepCnt,
   output dbg_state_e        dbgState
);

   localparam dbg_state_e        RESET_STATE = RESET_RUN ? DBG_ST_RUN : DBG_ST_HALT;
   localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

   dbg_state_e        state, state_n;
   logic [1:0]        cause, cause_n;
   logic [STEP_W-1:0] step_cnt, step_cnt_n;

   logic              active;
   logic              bp_hit;
   logic              cpu_en;
   logic              cmd_ready;
   logic              cmd_fire;
   logic              resume;
   logic [STEP_W-1:0] step_arg;
   logic [STEP_W-1:0] step_load;

   // Upper cmdArg bits (and pc when no breakpoint is built) have no reader.
   logic              unused_inputs;
   assign unused_inputs = ^{pc, cmdArg};

   assign active    = (state != DBG_ST_HALT);
   assign cpu_en    = active && !haltReq && !bp_hit;
   assign cmd_ready = !haltReq && !bp_hit && (state != DBG_ST_STEP);
   assign cmd_fire  = cmdValid && cmd_ready;
   assign resume    = cmd_fire && !active && op_resumes(cmdOp);

   // A zero step count would otherwise park the core in STEP forever.
   assign step_arg  = cmdArg[STEP_W-1:0];
   assign step_load = (step_arg == '0) ? STEP_ONE : step_arg;

`ifdef SM_DEBUG_BREAKPOINT_EN
   logic set_bp;
   logic clr_bp;

   assign set_bp = cmd_fire && (cmdOp == DBG_OP_SET_BP);
   assign clr_bp = cmd_fire && (cmdOp == DBG_OP_CLR_BP);

   sm_debug_bp u_bp (
      .clk    (clk),
      .rst_n  (rst_n),
      .set_bp (set_bp),
      .clr_bp (clr_bp),
      .addr   (cmdArg),
      .pc     (pc),
      .active (active),
      .resume (resume),
      .cpu_en (cpu_en),
      .bp_hit (bp_hit)
   );
`else
   logic unused_resume;
   assign unused_resume = resume;
   assign bp_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RESET_STATE;
         cause    <= DBG_CAUSE_RESET;
         step_cnt <= '0;
      end else begin
         state    <= state_n;
         cause    <= cause_n;
         step_cnt <= step_cnt_n;
      end
   end

   // Priority: haltReq > breakpoint > step expiry > command.
   // haltCause is written only when HALT is entered from RUN/STEP.
   always_comb begin
      state_n    = state;
      cause_n    = cause;
      step_cnt_n = step_cnt;

      if (haltReq) begin
         state_n = DBG_ST_HALT;
         if (active) begin
            cause_n = DBG_CAUSE_HALT;
         end
      end else if (bp_hit) begin
         state_n = DBG_ST_HALT;
         cause_n = DBG_CAUSE_BP;
      end else begin
         // Here cpu_en is 1 whenever state is STEP; the count never wraps.
         if ((state == DBG_ST_STEP) && (step_cnt != '0)) begin
            if (step_cnt == STEP_ONE) begin
               state_n    = DBG_ST_HALT;
               cause_n    = DBG_CAUSE_STEP;
               step_cnt_n = '0;
            end else begin
               step_cnt_n = step_cnt - STEP_ONE;
            end
         end

         // cmd_fire is never set in STEP, so it cannot collide with expiry.
         if (cmd_fire) begin
            case (cmdOp)
               DBG_OP_HALT: begin
                  state_n = DBG_ST_HALT;
                  if (active) begin
                     cause_n = DBG_CAUSE_HALT;
                  end
               end
               DBG_OP_RUN: begin
                  state_n = DBG_ST_RUN;
               end
               DBG_OP_STEP: begin
                  state_n    = DBG_ST_STEP;
                  step_cnt_n = step_load;
               end
               DBG_OP_NOP, DBG_OP_SET_BP, DBG_OP_CLR_BP: begin
                  // Breakpoint registers live in sm_debug_bp; state holds.
               end
               default: begin
                  // Reserved opcodes are treated as NOP.
               end
            endcase
         end
      end
   end

   assign cpuEn     = cpu_en;
   assign cmdReady  = cmd_ready;
   assign halted    = (state == DBG_ST_HALT);
   assign haltCause = cause;
   assign stepCnt   = step_cnt;
   assign dbgState  = state;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sm_debug_ctrl
// Self-checking bench for sm_debug_ctrl (STEP_W=16, RESET_RUN=1). A tiny
// CPU model advances pc whenever cpuEn is 1. Each scenario task pushes the
// expected per-cycle {cpuEn, halted, haltCause, stepCnt} vector into exp_q,
// then drives the cycles and pops/compares one entry per cycle. Breakpoint
// expectations follow SM_DEBUG_BREAKPOINT_EN.
// ---------------------------------------------------------------------------
module tb_sm_debug_ctrl;
   import sm_debug_ctrl_pkg::*;

   localparam int W = 20;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        halt_req;
   logic [31:0] pc;
   logic        cpu_en;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [15:0] step_cnt;
   dbg_state_e  dbg_state;

   logic        pc_load;
   logic [31:0] pc_load_val;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs;
   int           checks;
   int           errors;

   assign obs = {cpu_en, halted, halt_cause, step_cnt};

   sm_debug_ctrl #(.STEP_W(16), .RESET_RUN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmdValid  (cmd_valid),
      .cmdReady  (cmd_ready),
      .cmdOp     (cmd_op),
      .cmdArg    (cmd_arg),
      .haltReq   (halt_req),
      .pc        (pc),
      .cpuEn     (cpu_en),
      .halted    (halted),
      .haltCause (halt_cause),
      .stepCnt   (step_cnt),
      .dbgState  (dbg_state)
   );

   // ---------------- clock / reset / CPU model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pc_load) pc <= pc_load_val;
      else if (cpu_en) pc <= pc + 32'd1;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_cmd(input logic [2:0] op, input logic [31:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
   endtask

   task automatic drive_idle();
      cmd_valid = 1'b0;
      cmd_op    = DBG_OP_NOP;
      cmd_arg   = '0;
   endtask

   function automatic void push_exp(input logic en, input logic hl,
                                    input logic [1:0] cause, input logic [15:0] cnt);
      exp_q.push_back({en, hl, cause, cnt});
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [W-1:0] e;
      int cyc;
      @(negedge clk); #1;
      checks++;
      if (obs !== {1'b1, 1'b0, 2'b00, 16'd0}) begin
         errors++; $display("FAIL reset_in_reset: got %h want %h", obs, {1'b1, 1'b0, 2'b00, 16'd0});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
      end
      checks++;
      if (dbg_state !== DBG_ST_RUN) begin
         errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, DBG_ST_RUN);
      end
      repeat (3) push_exp(1'b1, 1'b0, 2'b00, 16'd0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (cyc == 0) begin rst_n = 1'b1; pc_load = 1'b0; end
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL reset_release cyc %0d: got %h want %h", cyc, obs, e);
         end
         cyc++;
      end
   endtask

   task automatic test_halt_cmd();
      logic [W-1:0] e;
      int cyc;
      push_exp(1'b1, 1'b0, 2'b00, 16'd0);   // HALT accepted, this cycle still retires
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (cyc == 0) drive_cmd(DBG_OP_HALT, 32'd0);
         else drive_idle();
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL halt_cmd cyc %0d: got %h want %h", cyc, obs, e);
         end
         if (cyc == 1) begin
            checks++;
            if (dbg_state !== DBG_ST_HALT) begin
               errors++; $display("FAIL halt_cmd_state: got %0d want %0d", dbg_state, DBG_ST_HALT);
            end
         end
         cyc++;
      end
   endtask

   task automatic test_step3();
      logic [W-1:0] e;
      logic [31:0] pc_start;
      int cyc;
      pc_start = '0;
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
      push_exp(1'b1, 1'b0, 2'b01, 16'd3);
      push_exp(1'b1, 1'b0, 2'b01, 16'd2);
      push_exp(1'b1, 1'b0, 2'b01, 16'd1);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (cyc == 0) drive_cmd(DBG_OP_STEP, 32'd3);
         else if (cyc <= 3) drive_cmd(DBG_OP_RUN, 32'd0);  // must be refused in STEP
         else drive_idle();
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL step3 cyc %0d: got %h want %h", cyc, obs, e);
         end
         if (cyc == 1) begin
            pc_start = pc;
            checks++;
            if (cmd_ready !== 1'b0) begin
               errors++; $display("FAIL step3_ready: got %b want 0", cmd_ready);
            end
         end
         if (cyc == 5) begin
            checks++;
            if (pc - pc_start !== 32'd3) begin
               errors++; $display("FAIL step3_retired: got %0d want 3", pc - pc_start);
            end
         end
         cyc++;
      end
   endtask

   task automatic test_step0();
      logic [W-1:0] e;
      int cyc;
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b1, 1'b0, 2'b10, 16'd1);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (cyc == 0) drive_cmd(DBG_OP_STEP, 32'd0);
         else drive_idle();
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL step0 cyc %0d: got %h want %h", cyc, obs, e);
         end
         cyc++;
      end
   endtask

   // haltReq coincides with step expiry (and, when built, a breakpoint hit).
   task automatic test_priority();
      logic [W-1:0] e;
      int cyc;
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b1, 1'b0, 2'b10, 16'd2);
      push_exp(1'b0, 1'b0, 2'b10, 16'd1);   // haltReq drops cpuEn at once
      push_exp(1'b0, 1'b1, 2'b01, 16'd1);
      push_exp(1'b0, 1'b1, 2'b01, 16'd1);   // haltReq while halted keeps cause
      push_exp(1'b0, 1'b1, 2'b01, 16'd1);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         pc_load  = 1'b0;
         halt_req = 1'b0;
         case (cyc)
            0: begin drive_cmd(DBG_OP_SET_BP, 32'h40); pc_load = 1'b1; pc_load_val = 32'h3F; end
            1: drive_cmd(DBG_OP_STEP, 32'd2);
            3: begin halt_req = 1'b1; drive_cmd(DBG_OP_RUN, 32'd0); end
            4: drive_cmd(DBG_OP_CLR_BP, 32'd0);
            5: begin halt_req = 1'b1; drive_idle(); end
            default: drive_idle();
         endcase
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL priority cyc %0d: got %h want %h", cyc, obs, e);
         end
         if (cyc == 3) begin
            checks++;
            if (cmd_ready !== 1'b0 || pc !== 32'h40) begin
               errors++; $display("FAIL priority_ready: got ready=%b pc=%h want ready=0 pc=40", cmd_ready, pc);
            end
         end
         cyc++;
      end
      halt_req = 1'b0;
   endtask

   task automatic test_run_to_step();
      logic [W-1:0] e;
      int cyc;
      push_exp(1'b0, 1'b1, 2'b01, 16'd1);
      push_exp(1'b1, 1'b0, 2'b01, 16'd1);
      push_exp(1'b1, 1'b0, 2'b01, 16'd2);   // STEP in RUN reloads the counter
      push_exp(1'b1, 1'b0, 2'b01, 16'd1);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (cyc == 0) drive_cmd(DBG_OP_RUN, 32'd0);
         else if (cyc == 1) drive_cmd(DBG_OP_STEP, 32'd2);
         else drive_idle();
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL run_to_step cyc %0d: got %h want %h", cyc, obs, e);
         end
         cyc++;
      end
   endtask

   task automatic test_breakpoint();
      logic [W-1:0] e;
      int cyc;
`ifdef SM_DEBUG_BREAKPOINT_EN
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      repeat (16) push_exp(1'b1, 1'b0, 2'b10, 16'd0);  // pc 0x00..0x0F
      push_exp(1'b0, 1'b0, 2'b10, 16'd0);              // pc 0x10 hit
      push_exp(1'b0, 1'b1, 2'b11, 16'd0);
      push_exp(1'b0, 1'b1, 2'b11, 16'd0);
      push_exp(1'b1, 1'b0, 2'b11, 16'd0);              // resume executes 0x10
      push_exp(1'b1, 1'b0, 2'b11, 16'd0);
      push_exp(1'b1, 1'b0, 2'b11, 16'd0);
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
`else
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      push_exp(1'b0, 1'b1, 2'b10, 16'd0);
      repeat (25) push_exp(1'b1, 1'b0, 2'b10, 16'd0);  // runs straight past 0x10
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
`endif
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         pc_load = 1'b0;
`ifdef SM_DEBUG_BREAKPOINT_EN
         case (cyc)
            0:  begin drive_cmd(DBG_OP_SET_BP, 32'h10); pc_load = 1'b1; pc_load_val = 32'h0; end
            1:  drive_cmd(DBG_OP_RUN, 32'd0);
            20: drive_cmd(DBG_OP_RUN, 32'd0);
            22: drive_cmd(DBG_OP_CLR_BP, 32'd0);
            23: drive_cmd(DBG_OP_HALT, 32'd0);
            default: drive_idle();
         endcase
`else
         case (cyc)
            0:  begin drive_cmd(DBG_OP_SET_BP, 32'h10); pc_load = 1'b1; pc_load_val = 32'h0; end
            1:  drive_cmd(DBG_OP_RUN, 32'd0);
            26: drive_cmd(DBG_OP_HALT, 32'd0);
            default: drive_idle();
         endcase
`endif
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL breakpoint cyc %0d: got %h want %h", cyc, obs, e);
         end
`ifdef SM_DEBUG_BREAKPOINT_EN
         if (cyc == 18) begin
            checks++;
            if (cmd_ready !== 1'b0 || pc !== 32'h10) begin
               errors++; $display("FAIL bp_hit_cycle: got ready=%b pc=%h want ready=0 pc=10", cmd_ready, pc);
            end
         end
         if (cyc == 22) begin
            checks++;
            if (pc !== 32'h11) begin
               errors++; $display("FAIL bp_resume_pc: got %h want 11", pc);
            end
         end
`else
         if (cyc == 27) begin
            checks++;
            if (pc !== 32'd25) begin
               errors++; $display("FAIL nobp_pc: got %0d want 25", pc);
            end
         end
`endif
         cyc++;
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] e;
      int cyc;
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
      push_exp(1'b0, 1'b1, 2'b01, 16'd0);
      push_exp(1'b1, 1'b0, 2'b01, 16'd100);
      push_exp(1'b1, 1'b0, 2'b01, 16'd99);
      push_exp(1'b1, 1'b0, 2'b01, 16'd98);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         pc_load = 1'b0;
         case (cyc)
            0: begin drive_cmd(DBG_OP_SET_BP, 32'h10); pc_load = 1'b1; pc_load_val = 32'h0; end
            1: drive_cmd(DBG_OP_STEP, 32'd100);
            default: drive_idle();
         endcase
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL async_step cyc %0d: got %h want %h", cyc, obs, e);
         end
         cyc++;
      end
      // Reset lands between clock edges and must act without one.
      @(negedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== {1'b1, 1'b0, 2'b00, 16'd0} || dbg_state !== DBG_ST_RUN) begin
         errors++; $display("FAIL async_reset: got %h state %0d want %h state %0d",
                            obs, dbg_state, {1'b1, 1'b0, 2'b00, 16'd0}, DBG_ST_RUN);
      end
      // After reset the breakpoint is gone: running through 0x10 never stops.
      repeat (20) push_exp(1'b1, 1'b0, 2'b00, 16'd0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         pc_load = 1'b0;
         if (cyc == 0) begin rst_n = 1'b1; pc_load = 1'b1; pc_load_val = 32'h0; end
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL post_reset_run cyc %0d: got %h want %h", cyc, obs, e);
         end
         if (cyc == 19) begin
            checks++;
            if (pc !== 32'd18) begin
               errors++; $display("FAIL post_reset_pc: got %0d want 18", pc);
            end
         end
         cyc++;
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      halt_req    = 1'b0;
      pc_load     = 1'b1;
      pc_load_val = 32'h0;
      drive_idle();
      test_reset();
      test_halt_cmd();
      test_step3();
      test_step0();
      test_priority();
      test_run_to_step();
      test_breakpoint();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
